// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared combinational ALU: port 0 is the instruction
// datapath, port 1 the PC-increment path. Optional round-robin arbitration: ALU_ARB_RR_EN.
module alu_arbiter #(
    parameter int DATA_BUS_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      r0_valid,
    output logic                      r0_ready,
    input  logic [3:0]                r0_op,
    input  logic [DATA_BUS_WIDTH-1:0] r0_a,
    input  logic [DATA_BUS_WIDTH-1:0] r0_b,
    output logic                      r0_rsp_valid,
    input  logic                      r0_rsp_ready,
    output logic [DATA_BUS_WIDTH-1:0] r0_result,
    output logic [1:0]                r0_flag,

    input  logic                      r1_valid,
    output logic                      r1_ready,
    input  logic [3:0]                r1_op,
    input  logic [DATA_BUS_WIDTH-1:0] r1_a,
    input  logic [DATA_BUS_WIDTH-1:0] r1_b,
    output logic                      r1_rsp_valid,
    input  logic                      r1_rsp_ready,
    output logic [DATA_BUS_WIDTH-1:0] r1_result,
    output logic [1:0]                r1_flag,

    output logic [3:0]                alu_op,
    output logic [DATA_BUS_WIDTH-1:0] alu_a,
    output logic [DATA_BUS_WIDTH-1:0] alu_b,
    input  logic [DATA_BUS_WIDTH-1:0] alu_result,
    input  logic [1:0]                alu_flag,

    output logic [1:0]                flags_q,
    output logic                      busy
);

    // The arbiter only needs to know the idle opcode; everything else passes through.
    localparam logic [3:0] OP_NOP = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                      state_q;
    logic                        gnt_q;
    logic                        gnt_d;
    logic                        hs_d;
    logic                        rsp_ready_d;
    logic [3:0]                  sel_op_d;
    logic [DATA_BUS_WIDTH-1:0]   sel_a_d;
    logic [DATA_BUS_WIDTH-1:0]   sel_b_d;
    logic [3:0]                  alu_op_q;
    logic [DATA_BUS_WIDTH-1:0]   alu_a_q;
    logic [DATA_BUS_WIDTH-1:0]   alu_b_q;
    logic [DATA_BUS_WIDTH-1:0]   result_q [2];
    logic [1:0]                  flag_q   [2];
    logic [1:0]                  rsp_valid_q;
`ifdef ALU_ARB_RR_EN
    logic                        last_grant_q;
`endif

    always_comb begin
        gnt_d = 1'b0;
`ifdef ALU_ARB_RR_EN
        if (r0_valid && r1_valid) begin
            gnt_d = ~last_grant_q;
        end else begin
            gnt_d = r1_valid;
        end
`else
        gnt_d = ~r0_valid & r1_valid;
`endif
    end

    always_comb begin
        r0_ready    = (state_q == IDLE) && r0_valid && !gnt_d;
        r1_ready    = (state_q == IDLE) && r1_valid && gnt_d;
        hs_d        = r0_ready || r1_ready;
        sel_op_d    = gnt_d ? r1_op : r0_op;
        sel_a_d     = gnt_d ? r1_a  : r0_a;
        sel_b_d     = gnt_d ? r1_b  : r0_b;
        rsp_ready_d = gnt_q ? r1_rsp_ready : r0_rsp_ready;
    end

    // The ALU drive registers double as the request latch: loaded on the handshake,
    // returned to NOP/zero when the EXEC cycle ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= 1'b0;
            alu_op_q     <= OP_NOP;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            result_q[0]  <= '0;
            result_q[1]  <= '0;
            flag_q[0]    <= 2'b00;
            flag_q[1]    <= 2'b00;
            rsp_valid_q  <= 2'b00;
            flags_q      <= 2'b00;
`ifdef ALU_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs_d) begin
                        alu_op_q     <= sel_op_d;
                        alu_a_q      <= sel_a_d;
                        alu_b_q      <= sel_b_d;
                        gnt_q        <= gnt_d;
`ifdef ALU_ARB_RR_EN
                        last_grant_q <= gnt_d;
`endif
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    result_q[gnt_q]    <= alu_result;
                    flag_q[gnt_q]      <= alu_flag;
                    rsp_valid_q[gnt_q] <= 1'b1;
                    if (!gnt_q) begin
                        flags_q <= alu_flag;
                    end
                    alu_op_q <= OP_NOP;
                    alu_a_q  <= '0;
                    alu_b_q  <= '0;
                    state_q  <= RESP;
                end
                RESP: begin
                    if (rsp_ready_d) begin
                        rsp_valid_q <= 2'b00;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_op       = alu_op_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign r0_result    = result_q[0];
    assign r1_result    = result_q[1];
    assign r0_flag      = flag_q[0];
    assign r1_flag      = flag_q[1];
    assign r0_rsp_valid = rsp_valid_q[0];
    assign r1_rsp_valid = rsp_valid_q[1];
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; a small behavioural ALU closes the loop on the alu_* port.
`timescale 1ns/1ps
module tb_alu_arbiter;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_INC1 = 4'd6;
    localparam logic [3:0] OP_INC2 = 4'd7;
    localparam logic [3:0] OP_INC3 = 4'd8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
    logic [3:0] r0_op;
    logic [7:0] r0_a, r0_b, r0_result;
    logic [1:0] r0_flag;
    logic       r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
    logic [3:0] r1_op;
    logic [7:0] r1_a, r1_b, r1_result;
    logic [1:0] r1_flag;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [1:0] alu_flag;
    logic [1:0] flags_q;
    logic       busy;
    logic [8:0] alu_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_BUS_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r0_result(r0_result), .r0_flag(r0_flag),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .r1_result(r1_result), .r1_flag(r1_flag),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_flag(alu_flag),
        .flags_q(flags_q), .busy(busy)
    );

    // Behavioural ALU: flag = {carry/borrow, zero}; NOP suppresses the zero flag.
    always_comb begin
        alu_sum = 9'd0;
        case (alu_op)
            OP_ADD:  alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  alu_sum = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND:  alu_sum = {1'b0, alu_a & alu_b};
            OP_OR:   alu_sum = {1'b0, alu_a | alu_b};
            OP_XOR:  alu_sum = {1'b0, alu_a ^ alu_b};
            OP_INC1: alu_sum = {1'b0, alu_a} + 9'd1;
            OP_INC2: alu_sum = {1'b0, alu_a} + 9'd2;
            OP_INC3: alu_sum = {1'b0, alu_a} + 9'd3;
            default: alu_sum = 9'd0;
        endcase
        alu_result = alu_sum[7:0];
        alu_flag   = (alu_op == OP_NOP) ? 2'b00 : {alu_sum[8], alu_sum[7:0] == 8'd0};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        r0_valid = 0; r0_op = OP_NOP; r0_a = 0; r0_b = 0; r0_rsp_ready = 0;
        r1_valid = 0; r1_op = OP_NOP; r1_a = 0; r1_b = 0; r1_rsp_ready = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (r0_ready !== 1'b0) begin errors++; $display("FAIL reset_r0_ready got %b exp 0", r0_ready); end
        checks++; if (r1_ready !== 1'b0) begin errors++; $display("FAIL reset_r1_ready got %b exp 0", r1_ready); end
        checks++; if (alu_op !== OP_NOP || alu_a !== 8'h00 || alu_b !== 8'h00) begin
            errors++; $display("FAIL reset_alu_drive got op=%h a=%h b=%h exp 0/00/00", alu_op, alu_a, alu_b); end
        checks++; if (flags_q !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", flags_q); end
        checks++; if (busy !== 1'b0 || r0_rsp_valid !== 1'b0 || r1_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_status got busy=%b v0=%b v1=%b exp 0/0/0", busy, r0_rsp_valid, r1_rsp_valid); end
        checks++; if (r0_result !== 8'h00 || r1_result !== 8'h00 || r0_flag !== 2'b00 || r1_flag !== 2'b00) begin
            errors++; $display("FAIL reset_results got %h %h %b %b exp zeros", r0_result, r1_result, r0_flag, r1_flag); end
        $display("reset: busy=%b flags_q=%b alu_op=%h", busy, flags_q, alu_op);
    endtask

    task automatic test_add_r0();
        r0_valid = 1; r0_op = OP_ADD; r0_a = 8'hF0; r0_b = 8'h20; r0_rsp_ready = 1;
        #1;
        checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            errors++; $display("FAIL add_ready got r0=%b r1=%b exp 1/0", r0_ready, r1_ready); end
        tick();
        r0_valid = 0;
        checks++; if (busy !== 1'b1 || alu_op !== OP_ADD || alu_a !== 8'hF0 || alu_b !== 8'h20) begin
            errors++; $display("FAIL add_exec got busy=%b op=%h a=%h b=%h exp 1/1/f0/20", busy, alu_op, alu_a, alu_b); end
        checks++; if (r0_rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b exp 0", r0_rsp_valid); end
        tick();
        checks++; if (r0_rsp_valid !== 1'b1 || r0_result !== 8'h10 || r0_flag !== 2'b10) begin
            errors++; $display("FAIL add_resp got v=%b res=%h flag=%b exp 1/10/10", r0_rsp_valid, r0_result, r0_flag); end
        checks++; if (flags_q !== 2'b10) begin errors++; $display("FAIL add_flags_q got %b exp 10", flags_q); end
        checks++; if (alu_op !== OP_NOP || alu_a !== 8'h00 || r1_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL add_idle_alu got op=%h a=%h v1=%b exp 0/00/0", alu_op, alu_a, r1_rsp_valid); end
        $display("r0 ADD f0+20: result=%h flag=%b flags_q=%b", r0_result, r0_flag, flags_q);
        tick();
        checks++; if (r0_rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL add_done got v=%b busy=%b exp 0/0", r0_rsp_valid, busy); end
        r0_rsp_ready = 0;
    endtask

    task automatic test_inc_r1();
        r1_valid = 1; r1_op = OP_INC1; r1_a = 8'hFF; r1_rsp_ready = 1;
        #1;
        checks++; if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
            errors++; $display("FAIL inc1_ready got r1=%b r0=%b exp 1/0", r1_ready, r0_ready); end
        tick();
        r1_op = OP_INC3; r1_a = 8'hFE;
        checks++; if (alu_op !== OP_INC1 || alu_a !== 8'hFF) begin
            errors++; $display("FAIL inc1_exec got op=%h a=%h exp 6/ff", alu_op, alu_a); end
        tick();
        checks++; if (r1_rsp_valid !== 1'b1 || r1_result !== 8'h00 || r1_flag !== 2'b11) begin
            errors++; $display("FAIL inc1_resp got v=%b res=%h flag=%b exp 1/00/11", r1_rsp_valid, r1_result, r1_flag); end
        checks++; if (flags_q !== 2'b10 || r0_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL inc1_flags_q got %b v0=%b exp 10/0", flags_q, r0_rsp_valid); end
        $display("r1 INC1 ff: result=%h flag=%b flags_q=%b", r1_result, r1_flag, flags_q);
        // r1_valid held high: the next INC3 is accepted right after returning to IDLE
        tick();
        checks++; if (r1_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL b2b_ready got r1=%b busy=%b exp 1/0", r1_ready, busy); end
        tick();
        r1_valid = 0;
        tick();
        checks++; if (r1_rsp_valid !== 1'b1 || r1_result !== 8'h01 || r1_flag !== 2'b10 || flags_q !== 2'b10) begin
            errors++; $display("FAIL inc3_resp got v=%b res=%h flag=%b fq=%b exp 1/01/10/10",
                                r1_rsp_valid, r1_result, r1_flag, flags_q); end
        $display("r1 INC3 fe: result=%h flag=%b", r1_result, r1_flag);
        tick();
        r1_rsp_ready = 0;
    endtask

    task automatic test_tie();
        r0_valid = 1; r0_op = OP_SUB;  r0_a = 8'h05; r0_b = 8'h05; r0_rsp_ready = 1;
        r1_valid = 1; r1_op = OP_INC2; r1_a = 8'h10; r1_b = 8'h00; r1_rsp_ready = 1;
        #1;
        checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            errors++; $display("FAIL tie_first got r0=%b r1=%b exp 1/0", r0_ready, r1_ready); end
        tick();
        tick();
        checks++; if (r0_rsp_valid !== 1'b1 || r0_result !== 8'h00 || r0_flag !== 2'b01 || flags_q !== 2'b01) begin
            errors++; $display("FAIL tie_sub got v=%b res=%h flag=%b fq=%b exp 1/00/01/01",
                                r0_rsp_valid, r0_result, r0_flag, flags_q); end
        checks++; if (r1_rsp_valid !== 1'b0 || r1_ready !== 1'b0) begin
            errors++; $display("FAIL tie_r1_wait got v1=%b rdy1=%b exp 0/0", r1_rsp_valid, r1_ready); end
        tick();
`ifdef ALU_ARB_RR_EN
        checks++; if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
            errors++; $display("FAIL tie_second got r0=%b r1=%b exp 0/1", r0_ready, r1_ready); end
`else
        checks++; if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            errors++; $display("FAIL tie_second got r0=%b r1=%b exp 1/0", r0_ready, r1_ready); end
`endif
        r0_valid = 0;
        #1;
        checks++; if (r1_ready !== 1'b1) begin errors++; $display("FAIL tie_r1_ready got %b exp 1", r1_ready); end
        tick();
        r1_valid = 0;
        tick();
        checks++; if (r1_rsp_valid !== 1'b1 || r1_result !== 8'h12 || r1_flag !== 2'b00 || flags_q !== 2'b01) begin
            errors++; $display("FAIL tie_inc2 got v=%b res=%h flag=%b fq=%b exp 1/12/00/01",
                                r1_rsp_valid, r1_result, r1_flag, flags_q); end
        $display("tie: r0 SUB res=%h, r1 INC2 res=%h flags_q=%b", r0_result, r1_result, flags_q);
        tick();
        r0_rsp_ready = 0; r1_rsp_ready = 0;
    endtask

    task automatic test_stall();
        r0_valid = 1; r0_op = OP_AND; r0_a = 8'h3C; r0_b = 8'h0F; r0_rsp_ready = 0;
        tick();
        r0_op = OP_OR; r0_a = 8'hAA;
        r1_rsp_ready = 1;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (r0_rsp_valid !== 1'b1 || r0_result !== 8'h0C || r0_flag !== 2'b00) begin
                errors++; $display("FAIL stall_hold[%0d] got v=%b res=%h flag=%b exp 1/0c/00",
                                    i, r0_rsp_valid, r0_result, r0_flag); end
            checks++; if (r0_ready !== 1'b0 || busy !== 1'b1 || r1_rsp_valid !== 1'b0) begin
                errors++; $display("FAIL stall_state[%0d] got rdy=%b busy=%b v1=%b exp 0/1/0",
                                    i, r0_ready, busy, r1_rsp_valid); end
            tick();
        end
        checks++; if (flags_q !== 2'b00) begin errors++; $display("FAIL stall_flags_q got %b exp 00", flags_q); end
        r0_valid = 0; r1_rsp_ready = 0; r0_rsp_ready = 1;
        tick();
        checks++; if (busy !== 1'b0 || r0_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release got busy=%b v=%b exp 0/0", busy, r0_rsp_valid); end
        $display("stall: 5 cycles held result=%h, released busy=%b", r0_result, busy);
        r0_rsp_ready = 0;
    endtask

    task automatic test_reset_mid();
        r0_valid = 1; r0_op = OP_ADD; r0_a = 8'h80; r0_b = 8'h80; r0_rsp_ready = 1;
        tick();
        r0_op = OP_XOR; r0_a = 8'hAA; r0_b = 8'h55;
        tick();
        checks++; if (flags_q !== 2'b11 || r0_result !== 8'h00) begin
            errors++; $display("FAIL mid_pre got fq=%b res=%h exp 11/00", flags_q, r0_result); end
        tick();
        tick();
        r0_valid = 0;
        checks++; if (alu_op !== OP_XOR || busy !== 1'b1) begin
            errors++; $display("FAIL mid_exec got op=%h busy=%b exp 5/1", alu_op, busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || flags_q !== 2'b00 || alu_op !== OP_NOP || r0_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_async got busy=%b fq=%b op=%h v=%b exp 0/00/0/0",
                                busy, flags_q, alu_op, r0_rsp_valid); end
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (r0_rsp_valid !== 1'b0 || busy !== 1'b0 || r0_result !== 8'h00 || flags_q !== 2'b00) begin
                errors++; $display("FAIL mid_after[%0d] got v=%b busy=%b res=%h fq=%b exp 0/0/00/00",
                                    i, r0_rsp_valid, busy, r0_result, flags_q); end
        end
        $display("reset during EXEC: busy=%b flags_q=%b rsp_valid=%b", busy, flags_q, r0_rsp_valid);
        r0_rsp_ready = 0;
    endtask

    initial begin
        test_reset();
        test_add_r0();
        test_inc_r1();
        test_tie();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
